// File: rtl/dct_coeff_accumulator.sv
// dct_coeff_accumulator
// Computes one 8x8 2-D DCT coefficient F(k1,k2) by walking all 64 pixel
// positions, multiplying each level-shifted pixel by its Q10 cosine-product
// term and summing. The result is floored by 2^10, saturated to 16 bits and
// offered over a valid/ready handshake.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; k1/k2 latched and accumulator cleared on start
// RUN   | presenting addresses idx=0..63 on {n1,n2}, one per cycle
// DRAIN | three cycles letting the last pixel/product/accumulate retire
// DONE  | coeff_valid high, coeff_out held until coeff_ready

module dct_coeff_accumulator (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic        [2:0]  k1,
    input  logic        [2:0]  k2,
    output logic               busy,
    output logic        [2:0]  lut_k1,
    output logic        [2:0]  lut_k2,
    output logic        [2:0]  n1,
    output logic        [2:0]  n2,
    input  logic signed [31:0] cos_term,
    input  logic        [7:0]  pixel_in,
    output logic signed [15:0] coeff_out,
    output logic               coeff_valid,
    input  logic               coeff_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic        [5:0]  idx_q;
    logic        [1:0]  drain_q;
    logic        [2:0]  k1_q;
    logic        [2:0]  k2_q;
    logic               busy_q;
    logic               valid_q;
    logic signed [15:0] coeff_q;

    // Datapath pipeline registers.
    // cos_q/v0_q: S0 -> S1, cos term captured alongside the RAM read.
    // prod_q/v1_q: S1 -> S2, registered product.
    logic signed [31:0] cos_q,  cos_d;
    logic               v0_q,   v0_d;
    logic signed [31:0] prod_q, prod_d;
    logic               v1_q,   v1_d;
    logic signed [31:0] acc_q,  acc_d;

    logic signed [8:0]  pix_shift;
    logic signed [31:0] acc_shift;
    logic signed [15:0] sat_d;
    logic               start_accept;

    assign start_accept = (state_q == IDLE) && start;

    // Datapath next-state: level shift, truncated multiply, wrapping accumulate.
    always_comb begin
        cos_d     = cos_term;
        v0_d      = (state_q == RUN);
        pix_shift = $signed({1'b0, pixel_in}) - 9'sd128;
        // Only the low 32 bits of the 41-bit product are kept, so evaluating
        // the multiply in a 32-bit context yields exactly those bits.
        prod_d    = pix_shift * cos_q;
        v1_d      = v0_q;
        acc_d     = acc_q;
        if (start_accept) begin
            acc_d = 32'sd0;
        end else if (v1_q) begin
            acc_d = acc_q + prod_q;
        end
    end

    // Result path: floor-divide by 2^10 then clamp to the signed 16-bit range.
    always_comb begin
        acc_shift = acc_q >>> 10;
        sat_d     = acc_shift[15:0];
        if (acc_shift > 32'sd32767) begin
            sat_d = 16'sh7FFF;
        end else if (acc_shift < -32'sd32768) begin
            sat_d = 16'sh8000;
        end
    end

    // Datapath registers; reset discards any partial sum in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cos_q  <= 32'sd0;
            v0_q   <= 1'b0;
            prod_q <= 32'sd0;
            v1_q   <= 1'b0;
            acc_q  <= 32'sd0;
        end else begin
            cos_q  <= cos_d;
            v0_q   <= v0_d;
            prod_q <= prod_d;
            v1_q   <= v1_d;
            acc_q  <= acc_d;
        end
    end

    // Sequencer FSM with registered busy/valid/coefficient outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 6'd0;
            drain_q <= 2'd0;
            k1_q    <= 3'd0;
            k2_q    <= 3'd0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            coeff_q <= 16'sd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        k1_q    <= k1;
                        k2_q    <= k2;
                        idx_q   <= 6'd0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    idx_q <= idx_q + 6'd1;
                    if (idx_q == 6'd63) begin
                        drain_q <= 2'd0;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The last accumulate lands on the edge that moves
                    // drain_q to 2, so the sum is final when drain_q == 2.
                    if (drain_q == 2'd2) begin
                        coeff_q <= sat_d;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
                DONE: begin
                    if (coeff_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign coeff_valid = valid_q;
    assign coeff_out   = coeff_q;
    assign lut_k1      = k1_q;
    assign lut_k2      = k2_q;
    // Addresses are forced to zero whenever the walk is not active.
    assign n1          = (state_q == RUN) ? idx_q[5:3] : 3'd0;
    assign n2          = (state_q == RUN) ? idx_q[2:0] : 3'd0;

endmodule

// File: tb/tb_dct_coeff_accumulator.sv
// Scoreboard bench for dct_coeff_accumulator: a behavioural block buffer
// (registered read) and cosine LUT (combinational read) feed the DUT; the
// driver queues hand-computed coefficients and a monitor checks them at the
// handshake, together with the start-to-valid latency.

module tb_dct_coeff_accumulator;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic        [2:0]  k1;
    logic        [2:0]  k2;
    logic               busy;
    logic        [2:0]  lut_k1;
    logic        [2:0]  lut_k2;
    logic        [2:0]  n1;
    logic        [2:0]  n2;
    logic signed [31:0] cos_term;
    logic        [7:0]  pixel_in;
    logic signed [15:0] coeff_out;
    logic               coeff_valid;
    logic               coeff_ready;

    logic signed [31:0] lut_mem [64];
    logic        [7:0]  pix_mem [64];

    int    cyc = 0;
    int    start_cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;
    int    exp_q[$];
    string name_q[$];
    logic  prev_v = 1'b0;

    dct_coeff_accumulator dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .k1          (k1),
        .k2          (k2),
        .busy        (busy),
        .lut_k1      (lut_k1),
        .lut_k2      (lut_k2),
        .n1          (n1),
        .n2          (n2),
        .cos_term    (cos_term),
        .pixel_in    (pixel_in),
        .coeff_out   (coeff_out),
        .coeff_valid (coeff_valid),
        .coeff_ready (coeff_ready)
    );

    always #5 clk = ~clk;

    assign cos_term = lut_mem[{n1, n2}];
    always @(posedge clk) pixel_in <= pix_mem[{n1, n2}];
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: latency on valid rise, scoreboard pop on each handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (coeff_valid && !prev_v)
                check("latency", cyc - start_cyc, 67);
            if (coeff_valid && coeff_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0d, expected no output", coeff_out);
                end else begin
                    check(name_q.pop_front(), int'(coeff_out), exp_q.pop_front());
                end
            end
        end
        prev_v = coeff_valid;
    end

    task automatic fill(input int p, input int c);
        for (int i = 0; i < 64; i++) begin
            pix_mem[i] = 8'(p);
            lut_mem[i] = c;
        end
    endtask

    task automatic do_start(input logic [2:0] k1v, input logic [2:0] k2v);
        @(posedge clk);
        #1;
        k1    = k1v;
        k2    = k2v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start     = 1'b0;
        check("lut_k1_latched", int'(lut_k1), int'(k1v));
        check("lut_k2_latched", int'(lut_k2), int'(k2v));
        k1 = ~k1v;
        k2 = ~k2v;
    endtask

    task automatic wait_idle(input string nm);
        int i;
        for (i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (!busy) break;
        end
        if (i == 300) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: busy still %0d after 300 cycles, expected 0", nm, busy);
        end
    endtask

    task automatic run(input logic [2:0] k1v, input logic [2:0] k2v,
                       input string nm, input int exp);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        do_start(k1v, k2v);
        check({nm, "_lut_k1_hold"}, int'(lut_k1), int'(k1v));
        wait_idle(nm);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},      int'(busy),        0);
        check({tag, "_valid"},     int'(coeff_valid), 0);
        check({tag, "_coeff_out"}, int'(coeff_out),   0);
        check({tag, "_n1"},        int'(n1),          0);
        check({tag, "_n2"},        int'(n2),          0);
        check({tag, "_lut_k1"},    int'(lut_k1),      0);
        check({tag, "_lut_k2"},    int'(lut_k2),      0);
    endtask

    initial begin
        int i;
        reset       = 1'b1;
        start       = 1'b0;
        k1          = 3'd0;
        k2          = 3'd0;
        coeff_ready = 1'b1;
        fill(128, 0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        reset = 1'b0;

        // Zero-valued pixels after level shift give a zero coefficient.
        fill(128, 32'h55);
        run(3'd6, 3'd7, "flat128", 0);

        // DC of a white block: 127*128*64 = 1040384, >>> 10 = 1016.
        fill(255, 128);
        run(3'd0, 3'd0, "dc_white", 1016);

        // Single impulse at (0,0): 127*19 = 2413 -> 2.
        fill(128, 32'h13);
        pix_mem[0] = 8'd255;
        run(3'd6, 3'd7, "impulse_00", 2);

        // Impulse at (0,1) with negative term: 127*-54 = -6858 -> floor -7.
        fill(128, -54);
        pix_mem[1] = 8'd255;
        run(3'd6, 3'd7, "neg_floor", -7);

        // Dark impulse at (0,1): -128*-54 = 6912 -> 6.
        pix_mem[1] = 8'd0;
        run(3'd6, 3'd7, "dark_impulse", 6);

        // 127*8192*64 >>> 10 = 65024 -> clamps to +32767.
        fill(255, 8192);
        run(3'd0, 3'd0, "sat_pos", 32767);

        // -128*8192*64 >>> 10 = -65536 -> clamps to -32768.
        fill(0, 8192);
        run(3'd0, 3'd0, "sat_neg", -32768);

        // Backpressure: hold ready low in DONE, pulse start, then release.
        fill(128, 32'h13);
        pix_mem[0] = 8'd255;
        coeff_ready = 1'b0;
        exp_q.push_back(2);
        name_q.push_back("bp_result");
        do_start(3'd6, 3'd7);
        for (i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (coeff_valid) break;
        end
        if (i == 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL bp_valid_timeout: coeff_valid %0d after 200 cycles, expected 1", coeff_valid);
        end
        for (int j = 0; j < 10; j++) begin
            @(posedge clk);
            #1;
            start = (j == 4);
            check("bp_valid_held", int'(coeff_valid), 1);
            check("bp_value_held", int'(coeff_out),   2);
            check("bp_busy_held",  int'(busy),        1);
        end
        // Release ready with start also high during the handshake cycle.
        coeff_ready = 1'b1;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("hs_busy_low",  int'(busy),        0);
        check("hs_valid_low", int'(coeff_valid), 0);
        @(posedge clk);
        #1;
        check("hs_start_ignored", int'(busy), 0);

        // Reset mid-RUN at idx 30 (n1=3, n2=6).
        fill(255, 128);
        do_start(3'd1, 3'd2);
        for (i = 0; i < 100; i++) begin
            if (n1 == 3'd3 && n2 == 3'd6) break;
            @(posedge clk);
            #1;
        end
        if (i == 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL idx30_timeout: n1=%0d n2=%0d, expected 3/6", n1, n2);
        end
        reset = 1'b1;
        #1;
        check_reset_vals("midrun");
        @(posedge clk);
        #1;
        reset = 1'b0;
        run(3'd0, 3'd0, "after_reset", 1016);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
